// File: rtl/pulse_handshake_tx.sv
`timescale 1ns/1ps
// pulse_handshake_tx
//
// Initiator side of a four-phase req/ack crossing. A one-cycle strobe with a
// data word in the outclk domain becomes a level request (req_out) to a
// slower or unrelated domain. The word is held on data_out while the request
// is up, and the request is released once the far side's acknowledge has been
// synchronized back. Strobes that arrive while a handshake is in flight are
// reported on dropped and never queued or overwritten.
//
// Ports:
//   outclk      in   fast clock; all state lives in this domain
//   reset       in   synchronous, active-high
//   pulse_in    in   one-cycle request strobe
//   data_in     in   DATA_W word captured with an accepted strobe
//   ack_async   in   acknowledge from the far domain (asynchronous)
//   req_out     out  registered level request to the far domain
//   data_out    out  registered data, stable while req_out is high
//   busy        out  high whenever pulse_in would not be accepted
//   done        out  one-cycle pulse when a handshake completes
//   dropped     out  one-cycle pulse when a strobe is rejected
//   timeout_err out  sticky timeout-abort flag, cleared only by reset
module pulse_handshake_tx #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              outclk,
  input  logic              reset,
  input  logic              pulse_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic              ack_async,
  output logic              req_out,
  output logic [DATA_W-1:0] data_out,
  output logic              busy,
  output logic              done,
  output logic              dropped,
  output logic              timeout_err
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  // A zero TIMEOUT_CYC disables the abort; the compare value is then unused.
  localparam bit          TIMEOUT_EN   = (TIMEOUT_CYC != 0);
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYC - 1);

  state_t                  state_r;
  state_t                  state_s;
  logic [SYNC_STAGES-1:0]  ack_sync_r;
  logic                    ack_sync_s;
  logic [15:0]             cnt_r;
  logic [15:0]             cnt_s;
  logic                    req_s;
  logic [DATA_W-1:0]       data_s;
  logic                    busy_s;
  logic                    done_s;
  logic                    dropped_s;
  logic                    timeout_err_s;

  // Acknowledge synchronizer: ack_async enters at bit 0, ack_sync is the last flop.
  always_ff @(posedge outclk) begin
    if (reset) begin
      ack_sync_r <= '0;
    end else begin
      ack_sync_r <= {ack_sync_r[SYNC_STAGES-2:0], ack_async};
    end
  end

  assign ack_sync_s = ack_sync_r[SYNC_STAGES-1];

  // Next-state and next-output logic of the handshake FSM.
  always_comb begin
    state_s       = state_r;
    req_s         = req_out;
    data_s        = data_out;
    cnt_s         = cnt_r;
    timeout_err_s = timeout_err;
    done_s        = 1'b0;
    busy_s        = 1'b1;
    case (state_r)
      ST_IDLE: begin
        // A stale high acknowledge (e.g. after a reset mid-handshake) must
        // drain before a new request may be raised.
        busy_s = ack_sync_s;
        if (pulse_in && !ack_sync_s) begin
          data_s  = data_in;
          req_s   = 1'b1;
          cnt_s   = 16'd0;
          state_s = ST_REQ;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (ack_sync_s) begin
          req_s   = 1'b0;
          state_s = ST_RELEASE;
        end else if (TIMEOUT_EN && (cnt_r == TIMEOUT_LAST)) begin
          // Abort: drop the request and wait for the far side to be low
          // like a normal release, so done still closes the transaction.
          req_s         = 1'b0;
          timeout_err_s = 1'b1;
          state_s       = ST_RELEASE;
        end else begin
          cnt_s = cnt_r + 16'd1;
        end
      end
      ST_RELEASE: begin
        if (!ack_sync_s) begin
          done_s  = 1'b1;
          state_s = ST_IDLE;
        end else begin
          state_s = ST_RELEASE;
        end
      end
      default: begin
        req_s   = 1'b0;
        state_s = ST_IDLE;
      end
    endcase
    dropped_s = pulse_in && busy_s;
  end

  // FSM state, counter and registered outputs.
  always_ff @(posedge outclk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      cnt_r       <= 16'd0;
      req_out     <= 1'b0;
      data_out    <= '0;
      done        <= 1'b0;
      dropped     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      req_out     <= req_s;
      data_out    <= data_s;
      done        <= done_s;
      dropped     <= dropped_s;
      timeout_err <= timeout_err_s;
    end
  end

  // busy is derived only from registered state, so it moves with the clock.
  assign busy = busy_s;

endmodule

// File: tb/tb_pulse_handshake_tx.sv
`timescale 1ns/1ps
// Self-checking bench for pulse_handshake_tx: directed scenarios plus a
// randomized run against a transaction-level reference model.
module tb_pulse_handshake_tx;

  localparam int DW = 8;
  localparam int SS = 2;
  localparam int TO = 8;

  logic          outclk    = 1'b0;
  logic          reset     = 1'b1;
  logic          pulse_in  = 1'b0;
  logic [DW-1:0] data_in   = '0;
  logic          ack_async = 1'b0;
  logic          req_out;
  logic [DW-1:0] data_out;
  logic          busy;
  logic          done;
  logic          dropped;
  logic          timeout_err;

  pulse_handshake_tx #(
    .DATA_W      (DW),
    .SYNC_STAGES (SS),
    .TIMEOUT_CYC (TO)
  ) dut (
    .outclk      (outclk),
    .reset       (reset),
    .pulse_in    (pulse_in),
    .data_in     (data_in),
    .ack_async   (ack_async),
    .req_out     (req_out),
    .data_out    (data_out),
    .busy        (busy),
    .done        (done),
    .dropped     (dropped),
    .timeout_err (timeout_err)
  );

  always #5 outclk = ~outclk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_done   = 0;
  int n_drop   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- far-side responder ----------------
  // far_mode 0: follow req_out after far_lat cycles; 1: drive far_force.
  int  far_mode   = 1;
  bit  far_force  = 1'b0;
  bit  far_jitter = 1'b0;
  bit  far_rand   = 1'b0;
  int  far_lat    = 2;
  int  far_cnt    = 0;

  always @(negedge outclk) begin
    if (far_mode == 0) begin
      if (req_out !== ack_async) begin
        if (far_cnt >= far_lat) begin
          far_cnt = 0;
          if (far_rand) far_lat = $urandom_range(0, 3);
          if (far_jitter) #($urandom_range(0, 3));
          ack_async = req_out;
        end else begin
          far_cnt++;
        end
      end else begin
        far_cnt = 0;
      end
    end else begin
      ack_async = far_force;
    end
  end

  // ---------------- reference model ----------------
  // The model tracks a transaction: "requesting" while the request is up,
  // "releasing" while waiting for the far side to drop its ack. The ack seen
  // by the initiator is the ack_async sample taken SS edges earlier.
  bit          m_valid = 1'b0;
  bit          m_req, m_rel, m_done, m_drop, m_terr;
  logic [DW-1:0] m_data;
  int          m_age;
  bit          mq[$];

  function automatic bit m_busy();
    return m_req || m_rel || mq[SS-1];
  endfunction

  always @(posedge outclk) begin : model
    bit            seen_ack, was_busy, in_p, in_a;
    logic [DW-1:0] in_d;
    in_p = pulse_in;
    in_a = ack_async;
    in_d = data_in;
    if (reset) begin
      m_valid = 1'b1;
      m_req = 0; m_rel = 0; m_done = 0; m_drop = 0; m_terr = 0;
      m_data = '0; m_age = 0;
      mq.delete();
      for (int i = 0; i < SS; i++) mq.push_back(1'b0);
    end else if (m_valid) begin
      seen_ack = mq[SS-1];
      was_busy = m_req || m_rel || seen_ack;
      m_done = 0;
      m_drop = 0;
      if (m_rel) begin
        if (!seen_ack) begin m_rel = 0; m_done = 1; end
      end else if (m_req) begin
        if (seen_ack) begin
          m_req = 0; m_rel = 1;
        end else if (m_age + 1 == TO) begin
          m_req = 0; m_rel = 1; m_terr = 1;
        end else begin
          m_age++;
        end
      end
      if (in_p) begin
        if (was_busy) m_drop = 1;
        else begin m_req = 1; m_data = in_d; m_age = 0; end
      end
      mq.push_front(in_a);
      void'(mq.pop_back());
    end
  end

  // ---------------- per-cycle compare ----------------
  bit          prev_req  = 1'b0;
  logic [DW-1:0] prev_data = '0;

  always @(negedge outclk) begin
    if (m_valid) begin
      chk("cyc_req_out",     req_out,     m_req);
      chk("cyc_data_out",    data_out,    m_data);
      chk("cyc_busy",        busy,        m_busy());
      chk("cyc_done",        done,        m_done);
      chk("cyc_dropped",     dropped,     m_drop);
      chk("cyc_timeout_err", timeout_err, m_terr);
      if (prev_req && req_out === 1'b1) chk("cyc_data_hold", data_out, prev_data);
      prev_req  = (req_out === 1'b1);
      prev_data = data_out;
      if (done === 1'b1)    n_done++;
      if (dropped === 1'b1) n_drop++;
    end
  end

  // ---------------- helpers ----------------
  task automatic step();
    @(posedge outclk);
    #1;
  endtask

  task automatic wait_done(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (done === 1'b1) begin ok = 1'b1; break; end
      step();
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req_out"},     req_out,     1'b0);
    chk({tag, "_data_out"},    data_out,    8'h00);
    chk({tag, "_busy"},        busy,        1'b0);
    chk({tag, "_done"},        done,        1'b0);
    chk({tag, "_dropped"},     dropped,     1'b0);
    chk({tag, "_timeout_err"}, timeout_err, 1'b0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  // ---------------- directed and random stimulus ----------------
  initial begin
    bit ok;
    int bad, d0, p0, n, req_cnt, terr_idx, done_idx, done_cnt, pulses;

    reset = 1'b1;
    repeat (3) step();
    chk_reset_vals("rst");
    reset = 1'b0;
    step();

    // Single transfer of 0xA5, far side acks a few cycles later.
    far_mode = 0; far_lat = 2;
    data_in = 8'hA5; pulse_in = 1'b1;
    step();
    pulse_in = 1'b0; data_in = 8'h00;
    chk("t1_req_rise", req_out, 1'b1);
    chk("t1_data", data_out, 8'hA5);
    chk("t1_busy", busy, 1'b1);
    chk("t1_model_data", m_data, 8'hA5);
    bad = 0; ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (req_out === 1'b1 && data_out !== 8'hA5) bad++;
      if (done === 1'b1) begin ok = 1'b1; break; end
      step();
    end
    chk("t1_done_seen", ok, 1'b1);
    chk("t1_busy_low_with_done", busy, 1'b0);
    chk("t1_data_stable", bad, 0);

    // Pulse in the same cycle as done is accepted.
    data_in = 8'h3C; pulse_in = 1'b1;
    step();
    pulse_in = 1'b0;
    chk("t3_req_rise", req_out, 1'b1);
    chk("t3_data", data_out, 8'h3C);
    chk("t3_done_single", done, 1'b0);
    chk("t3_no_drop", dropped, 1'b0);
    wait_done(40, ok);
    chk("t3_done_seen", ok, 1'b1);
    repeat (2) step();

    // Back-to-back pulses 0x11 then 0x22.
    d0 = n_done; p0 = n_drop;
    data_in = 8'h11; pulse_in = 1'b1;
    step();
    data_in = 8'h22; pulse_in = 1'b1;
    step();
    pulse_in = 1'b0;
    chk("t2_data_first", data_out, 8'h11);
    wait_done(40, ok);
    chk("t2_done_seen", ok, 1'b1);
    repeat (3) step();
    chk("t2_drop_count", n_drop - p0, 1);
    chk("t2_done_count", n_done - d0, 1);
    chk("t2_data_kept", data_out, 8'h11);

    // Timeout: far side never acks.
    far_mode = 1; far_force = 1'b0;
    step();
    data_in = 8'h5A; pulse_in = 1'b1;
    step();
    pulse_in = 1'b0;
    req_cnt = 0; terr_idx = -1; done_idx = -1; done_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      if (req_out === 1'b1) req_cnt++;
      if (timeout_err === 1'b1 && terr_idx < 0) terr_idx = i;
      if (done === 1'b1) begin done_cnt++; if (done_idx < 0) done_idx = i; end
      step();
    end
    chk("t4_req_cycles", req_cnt, TO);
    chk("t4_terr_cycle", terr_idx, TO);
    chk("t4_done_after_terr", done_idx, terr_idx + 1);
    chk("t4_done_count", done_cnt, 1);
    chk("t4_terr_sticky", timeout_err, 1'b1);
    chk("t4_req_low", req_out, 1'b0);

    // Reset while in REQ with the far ack high.
    data_in = 8'h77; pulse_in = 1'b1;
    step();
    pulse_in = 1'b0;
    chk("t5_in_req", req_out, 1'b1);
    far_force = 1'b1; reset = 1'b1;
    step();
    chk_reset_vals("t5_rst");
    reset = 1'b0;
    repeat (SS) step();
    chk("t5_busy_stale_ack", busy, 1'b1);
    data_in = 8'h99; pulse_in = 1'b1;
    step();
    pulse_in = 1'b0;
    chk("t5_dropped", dropped, 1'b1);
    chk("t5_no_req", req_out, 1'b0);
    chk("t5_data_unchanged", data_out, 8'h00);
    far_force = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 10) begin step(); n++; end
    chk("t5_busy_clear", busy, 1'b0);
    chk("t5_clear_within_sync", (n <= SS), 1'b1);
    data_in = 8'hC3; pulse_in = 1'b1;
    step();
    pulse_in = 1'b0;
    chk("t5_accept_req", req_out, 1'b1);
    chk("t5_accept_data", data_out, 8'hC3);
    far_mode = 0;
    wait_done(40, ok);
    chk("t5_done_seen", ok, 1'b1);
    repeat (2) step();

    // Random traffic with jittered, randomly delayed acknowledge.
    far_rand = 1'b1; far_jitter = 1'b1;
    d0 = n_done; p0 = n_drop; pulses = 0;
    for (int k = 0; k < 1000; k++) begin
      repeat ($urandom_range(0, 10)) step();
      data_in = DW'($urandom);
      pulse_in = 1'b1;
      step();
      pulse_in = 1'b0;
      pulses++;
    end
    n = 0;
    while ((busy === 1'b1 || req_out === 1'b1) && n < 200) begin step(); n++; end
    chk("rnd_drained", busy, 1'b0);
    repeat (3) step();
    chk("rnd_done_plus_dropped", (n_done - d0) + (n_drop - p0), pulses);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pulse_handshake_tx.md
# pulse_handshake_tx

Initiator side of a four-phase req/ack crossing. Takes a one-cycle strobe and a data word in the `outclk` domain, and raises a level request to a slower or unrelated clock domain. The data is held stable until that domain's acknowledge is synchronized back and then released. This block is the counterpart of the slow-to-fast pulse synchronizer: it carries events fast-to-slow without loss or silent overwrite.

## Interface
Parameters:
- `DATA_W`, 8: width of the bundled data word.
- `SYNC_STAGES`, 2: flops in the `ack_async` synchronizer. Legal range 2–4.
- `TIMEOUT_CYC`, 1024: maximum `outclk` cycles in REQ before abort. 0 disables the timeout. Counter width is 16 bits.

Ports (one clock; reset is synchronous and active-high):
- `outclk`, in, 1: fast clock; all state is in this domain.
- `reset`, in, 1: synchronous, active-high.
- `pulse_in`, in, 1: one-cycle request strobe.
- `data_in`, in, `DATA_W`: captured together with an accepted `pulse_in`.
- `ack_async`, in, 1: acknowledge from the far domain; asynchronous to `outclk`.
- `req_out`, out, 1: registered level request to the far domain.
- `data_out`, out, `DATA_W`: registered; stable for as long as `req_out`=1.
- `busy`, out, 1: high whenever `pulse_in` would not be accepted.
- `done`, out, 1: one-cycle pulse when a handshake completes.
- `dropped`, out, 1: one-cycle pulse when `pulse_in`=1 is not accepted.
- `timeout_err`, out, 1: sticky; set on timeout abort, cleared only by `reset`.

## Operation
- Synchronizer: `ack_async` passes through `SYNC_STAGES` flops; the last flop is `ack_sync`. The FSM uses only `ack_sync`.
- States: IDLE, REQ, RELEASE.
- IDLE:
  - `busy` = `ack_sync`; a stale high ack blocks acceptance.
  - If `pulse_in`=1 and `ack_sync`=0: `data_out` <= `data_in`, `req_out` <= 1, timeout counter <= 0, go to REQ.
  - If `pulse_in`=1 and `ack_sync`=1: `dropped` <= 1, stay in IDLE.
- REQ:
  - `busy`=1.
  - If `ack_sync`=1: `req_out` <= 0, go to RELEASE.
  - Else, if `TIMEOUT_CYC`≠0 and counter = `TIMEOUT_CYC`-1: `req_out` <= 0, `timeout_err` <= 1, go to RELEASE.
  - Otherwise the counter increments.
- RELEASE:
  - `busy`=1.
  - If `ack_sync`=0: go to IDLE and `done` <= 1. `done` is also asserted after a timeout abort.
- `pulse_in` while `busy`=1 gives `dropped` <= 1. Nothing is queued, and `data_out` is unchanged.
- `data_out` changes only on an accepted request. It holds its value after the handshake completes.
- Simultaneous `pulse_in` and a completing handshake: `done` and `busy`=0 appear in the same cycle. A `pulse_in` in that cycle is accepted.

## Timing
- Reset values: state IDLE, `req_out`=0, `data_out`=0, `busy`=0, `done`=0, `dropped`=0, `timeout_err`=0, all synchronizer flops 0, counter 0.
- Reset mid-handshake: `req_out` drops on the next edge. If the far side still holds `ack_async` high, it synchronizes back and `busy` stays high in IDLE until `ack_sync` returns to 0.
- Accept latency: `pulse_in` sampled at edge E gives `req_out`=1 and the new `data_out` after E. `busy`=1 from the cycle after E.
- Ack latency: `ack_async` stable before edge A gives `ack_sync` high after edge A+`SYNC_STAGES`-1. The FSM reacts at edge A+`SYNC_STAGES`.
- Round trip with an immediately responding far side, `SYNC_STAGES`=2: 2 edges to enter RELEASE after the ack rises, 2 edges to return to IDLE after the ack falls. Far-domain latency adds to this.
- `done` and `dropped` are registered single-cycle pulses.
- Timeout abort: the REQ cycle count is exactly `TIMEOUT_CYC`, with `req_out` high for `TIMEOUT_CYC` cycles.

## Test plan
- Single transfer, `SYNC_STAGES`=2, `data_in`=0xA5 with a far model that acks 3 cycles after `req_out` rises:
  - `req_out` rises 1 cycle after the pulse.
  - `data_out`=0xA5 for the whole time `req_out` is high.
  - One `done` pulse; `busy` falls in the same cycle.
- Back-to-back pulses 0x11 then 0x22, with 0x22 issued 1 cycle after 0x11:
  - `dropped`=1 exactly once.
  - `data_out` stays 0x11.
  - Exactly one `done`.
- Pulse issued in the same cycle as `done`, with `data_in`=0x3C: accepted; `req_out` rises the next cycle with `data_out`=0x3C.
- `TIMEOUT_CYC`=8, far side never acks:
  - `req_out` high for 8 cycles, then low.
  - `timeout_err`=1 and stays 1.
  - `done` pulses once, one cycle after `timeout_err` rises.
- `reset` asserted while in REQ with `ack_async` high:
  - All outputs return to their reset values.
  - Once `ack_sync` rises, `busy` stays high and a `pulse_in` gives `dropped`.
  - After `ack_async` goes low, `busy`=0 within `SYNC_STAGES` cycles, and the next pulse is accepted.
- Random `ack_async` phase jitter relative to `outclk`, 1000 transfers:
  - `done` count plus `dropped` count equals the `pulse_in` count.
  - No `data_out` change while `req_out`=1.
